// File: rtl/freq_encode_pkg.sv
// Shared definitions for the freq_encode block: FSM state encoding,
// default counter width and synchronizer depth.
package freq_pkg;

   // Default width of the period / high-time counters and outputs.
   localparam int CNT_W_DEF = 20;

   // Number of flops in the pwm_in metastability synchronizer.
   localparam int SYNC_STAGES = 2;

   // Measurement FSM: IDLE waits for the first rise, MEASURE counts a period.
   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

endpackage : freq_pkg

// File: rtl/freq_encode_if.sv
// Measurement bus of freq_encode: the PWM input and the registered
// period / high-time results with their valid pulse and no-signal flag.
interface freq_encode_if
   import freq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);

   logic             pwm_in;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] high_cnt;
   logic             valid;
   logic             no_signal;

   // Stimulus / consumer side: drives the waveform, reads the results.
   modport master (
      output pwm_in,
      input  count,
      input  high_cnt,
      input  valid,
      input  no_signal
   );

   // Measuring block side.
   modport slave (
      input  pwm_in,
      output count,
      output high_cnt,
      output valid,
      output no_signal
   );

endinterface : freq_encode_if

// File: rtl/freq_encode_edge_sync.sv
// edge_sync: brings the asynchronous pwm_in into the clk domain through a
// SYNC_STAGES-deep flop chain and flags rising / falling transitions by
// comparing the synchronized level with its value one cycle earlier.
module edge_sync
   import freq_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Synchronizer shift chain plus one-cycle-delayed copy of its output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the old value
         // of its neighbour, so the chain really is SYNC_STAGES flops deep.
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule : edge_sync

// File: rtl/freq_encode.sv
// freq_encode: measures period and high time of pwm_in in clk cycles.
// A rise in MEASURE latches the running counters into count / high_cnt and
// pulses valid one cycle later (4 clk cycles after the pwm_in edge).
// TIMEOUT cycles without a rise drop back to IDLE and raise no_signal.
// Optional build macro FREQ_ENCODE_AVG_EN: report the truncated mean of
// four consecutive periods, with valid only on every fourth period.
module freq_encode
   import freq_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = 2**CNT_W - 1
)(
   input  logic          clk,
   input  logic          rst_n,
   freq_encode_if.slave  bus
);

   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] per_cnt;
   logic [CNT_W-1:0] hi_cnt;
   logic             hi_phase;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] high_q;
   logic             upd_q;
   logic             valid_q;
   logic             no_sig_q;

   logic             level;
   logic             rise;
   logic             fall;

   edge_sync u_edge_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (bus.pwm_in),
      .level (level),
      .rise  (rise),
      .fall  (fall)
   );

`ifdef FREQ_ENCODE_AVG_EN
   // Two extra bits hold the sum of four full-scale periods without overflow.
   logic [CNT_W+1:0] sum_per;
   logic [CNT_W+1:0] sum_hi;
   logic [CNT_W+1:0] sum_per_nxt;
   logic [CNT_W+1:0] sum_hi_nxt;
   logic [1:0]       idx;

   assign sum_per_nxt = sum_per + (CNT_W+2)'(per_cnt);
   assign sum_hi_nxt  = sum_hi  + (CNT_W+2)'(hi_cnt);
`endif

   // Measurement FSM: period / high-time counting, result capture, timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         per_cnt  <= '0;
         hi_cnt   <= '0;
         hi_phase <= 1'b0;
         count_q  <= '0;
         high_q   <= '0;
         upd_q    <= 1'b0;
         no_sig_q <= 1'b1;
`ifdef FREQ_ENCODE_AVG_EN
         sum_per  <= '0;
         sum_hi   <= '0;
         idx      <= '0;
`endif
      end else begin
         upd_q <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  state    <= MEASURE;
                  per_cnt  <= ONE;
                  hi_cnt   <= ONE;
                  hi_phase <= 1'b1;
               end
            end
            MEASURE: begin
               // A rise takes priority over a coincident timeout.
               if (rise) begin
                  per_cnt  <= ONE;
                  hi_cnt   <= ONE;
                  hi_phase <= 1'b1;
`ifdef FREQ_ENCODE_AVG_EN
                  idx <= idx + 2'd1;
                  if (idx == 2'd3) begin
                     count_q  <= sum_per_nxt[CNT_W+1:2];
                     high_q   <= sum_hi_nxt[CNT_W+1:2];
                     upd_q    <= 1'b1;
                     no_sig_q <= 1'b0;
                     sum_per  <= '0;
                     sum_hi   <= '0;
                  end else begin
                     sum_per  <= sum_per_nxt;
                     sum_hi   <= sum_hi_nxt;
                  end
`else
                  count_q  <= per_cnt;
                  high_q   <= hi_cnt;
                  upd_q    <= 1'b1;
                  no_sig_q <= 1'b0;
`endif
               end else if (per_cnt == TIMEOUT_V) begin
                  state    <= IDLE;
                  per_cnt  <= '0;
                  hi_cnt   <= '0;
                  hi_phase <= 1'b0;
                  count_q  <= '0;
                  high_q   <= '0;
                  no_sig_q <= 1'b1;
`ifdef FREQ_ENCODE_AVG_EN
                  sum_per  <= '0;
                  sum_hi   <= '0;
                  idx      <= '0;
`endif
               end else begin
                  per_cnt <= per_cnt + ONE;
                  // The high phase opened by the rise closes on the fall.
                  if (hi_phase && !fall) begin
                     hi_cnt <= hi_cnt + ONE;
                  end
                  if (fall) begin
                     hi_phase <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // valid trails the result capture by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= upd_q;
      end
   end

   assign bus.count     = count_q;
   assign bus.high_cnt  = high_q;
   assign bus.valid     = valid_q;
   assign bus.no_signal = no_sig_q;

endmodule : freq_encode

// File: tb/tb_freq_encode.sv
// Directed testbench for freq_encode (CNT_W=8, TIMEOUT=200).
// Inputs are driven and outputs sampled on the falling clk edge.
// Build with FREQ_ENCODE_AVG_EN defined to exercise the averaging variant.
module tb_freq_encode;

   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 200;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   vcnt;

   freq_encode_if #(.CNT_W(CNT_W)) bus ();

   freq_encode #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count valid pulses seen by the bench (sampled at the rising edge).
   always @(posedge clk) begin
      if (bus.valid === 1'b1) vcnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      vcnt        = 0;
      rst_n       = 1'b0;
      bus.pwm_in  = 1'b0;

      // Reset held with pwm_in toggling.
      for (int i = 0; i < 6; i++) begin
         tick(3);
         bus.pwm_in = ~bus.pwm_in;
      end
      tick(1);
      check("rst_count", 32'(bus.count), 0);
      check("rst_high", 32'(bus.high_cnt), 0);
      check("rst_valid", 32'(bus.valid), 0);
      check("rst_nosig", 32'(bus.no_signal), 1);
      bus.pwm_in = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);

`ifdef FREQ_ENCODE_AVG_EN
      // Four periods 100, 102, 98, 101 with 20-cycle high time.
      begin
         int per [4] = '{100, 102, 98, 101};
         for (int i = 0; i < 4; i++) begin
            bus.pwm_in = 1'b1; tick(20);
            bus.pwm_in = 1'b0; tick(per[i] - 20);
         end
      end
      check("avg_novalid_yet", 32'(vcnt), 0);
      check("avg_nosig_yet", 32'(bus.no_signal), 1);
      bus.pwm_in = 1'b1; tick(3);
      check("avg_valid_early", 32'(bus.valid), 0);
      tick(1);
      check("avg_valid", 32'(bus.valid), 1);
      check("avg_count", 32'(bus.count), 100);
      check("avg_high", 32'(bus.high_cnt), 20);
      check("avg_nosig", 32'(bus.no_signal), 0);
      tick(1);
      check("avg_valid_pulse", 32'(bus.valid), 0);
      bus.pwm_in = 1'b0; tick(40);
      check("avg_single_valid", 32'(vcnt), 1);
`else
      // Basic measurement: period 100, high 25.
      bus.pwm_in = 1'b1; tick(25);
      bus.pwm_in = 1'b0; tick(75);
      check("basic_no_valid_first", 32'(vcnt), 0);
      check("basic_nosig_first", 32'(bus.no_signal), 1);
      bus.pwm_in = 1'b1; tick(3);
      check("basic_valid_early", 32'(bus.valid), 0);
      tick(1);
      check("basic_valid", 32'(bus.valid), 1);
      check("basic_count", 32'(bus.count), 100);
      check("basic_high", 32'(bus.high_cnt), 25);
      check("basic_nosig", 32'(bus.no_signal), 0);
      tick(1);
      check("basic_valid_pulse", 32'(bus.valid), 0);
      tick(20);
      bus.pwm_in = 1'b0; tick(75);

      // Timeout: held low, 200 cycles after the detected rise.
      tick(102);
      check("to_nosig_before", 32'(bus.no_signal), 0);
      check("to_count_before", 32'(bus.count), 100);
      tick(1);
      check("to_nosig", 32'(bus.no_signal), 1);
      check("to_count", 32'(bus.count), 0);
      check("to_high", 32'(bus.high_cnt), 0);
      tick(5);
      check("to_no_valid", 32'(vcnt), 1);

      // Recovery: period 60, high 30.
      bus.pwm_in = 1'b1; tick(30);
      bus.pwm_in = 1'b0; tick(30);
      check("rec_no_valid_first", 32'(vcnt), 1);
      bus.pwm_in = 1'b1; tick(4);
      check("rec_valid", 32'(bus.valid), 1);
      check("rec_count", 32'(bus.count), 60);
      check("rec_high", 32'(bus.high_cnt), 30);

      // Tie: next period exactly TIMEOUT cycles.
      tick(26);
      bus.pwm_in = 1'b0; tick(170);
      bus.pwm_in = 1'b1; tick(3);
      check("tie_nosig_edge", 32'(bus.no_signal), 0);
      tick(1);
      check("tie_valid", 32'(bus.valid), 1);
      check("tie_count", 32'(bus.count), 200);
      check("tie_nosig", 32'(bus.no_signal), 0);

      // Reset 50 cycles into the next period.
      tick(26);
      bus.pwm_in = 1'b0; tick(20);
      rst_n = 1'b0;
      #1;
      check("mrst_count", 32'(bus.count), 0);
      check("mrst_high", 32'(bus.high_cnt), 0);
      check("mrst_valid", 32'(bus.valid), 0);
      check("mrst_nosig", 32'(bus.no_signal), 1);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      bus.pwm_in = 1'b1; tick(10);
      bus.pwm_in = 1'b0; tick(40);
      check("mrst_no_valid_first", 32'(vcnt), 3);
      check("mrst_nosig_first", 32'(bus.no_signal), 1);
      bus.pwm_in = 1'b1; tick(4);
      check("mrst_valid_second", 32'(bus.valid), 1);
      check("mrst_count_second", 32'(bus.count), 50);
      check("mrst_high_second", 32'(bus.high_cnt), 10);
      bus.pwm_in = 1'b0; tick(4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_freq_encode

// File: doc/freq_encode.md
FREQ_ENCODE -- requirements
Module: freq_encode

Interface
REQ-001 The block SHALL have parameter CNT_W, default 20, which sets the width of the measurement counters and outputs.
REQ-002 The block SHALL have parameter TIMEOUT, default 2**CNT_W-1, giving the period in clk cycles without a rising edge after which the input is declared dead; legal range is 2..2**CNT_W-1.
REQ-003 Port clk: input, 1 bit, the single system clock.
REQ-004 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port pwm_in: input, 1 bit, asynchronous PWM/square wave to be measured.
REQ-006 Port count: output, CNT_W bits, measured period in clk cycles.
REQ-007 Port high_cnt: output, CNT_W bits, measured high time in clk cycles.
REQ-008 Port valid: output, 1 bit, one-cycle pulse when count/high_cnt update.
REQ-009 Port no_signal: output, 1 bit, level asserted while no valid measurement exists.

Function
REQ-010 pwm_in SHALL pass through a 2-flop synchronizer; rise/fall SHALL be detected by comparing the synchronized level with its value one cycle earlier.
REQ-011 The FSM SHALL have two states: IDLE (waiting for the first rise) and MEASURE.
REQ-012 IDLE to MEASURE SHALL occur on rise, with per_cnt loaded to 1 and hi_cnt loaded to 1.
REQ-013 In MEASURE, per_cnt SHALL increment every cycle, and hi_cnt SHALL increment each cycle the synchronized level is high.
REQ-014 A pwm_in with period P cycles and high time H cycles SHALL yield count=P and high_cnt=H.
REQ-015 On rise in MEASURE, the block SHALL register count<=per_cnt and high_cnt<=hi_cnt, pulse valid on the next cycle, reload both counters to 1, and clear no_signal.
REQ-016 count and high_cnt SHALL be registered and held stable between updates.
REQ-017 Latency from a pwm_in rising edge to the valid pulse SHALL be 4 clk cycles.
REQ-018 In MEASURE, per_cnt==TIMEOUT with no rise SHALL cause the following in one step: go to IDLE, set no_signal=1, clear count and high_cnt to 0, and pulse no valid.
REQ-019 If rise and per_cnt==TIMEOUT occur in the same cycle, rise SHALL win and a normal measurement SHALL be produced.
REQ-020 An input held constantly high or low SHALL time out identically.
REQ-021 Counters SHALL never wrap; TIMEOUT bounds per_cnt, and hi_cnt<=per_cnt.

Reset
REQ-022 rst_n low SHALL immediately force the synchronizer flops to 0, state to IDLE, counters to 0, count=0, high_cnt=0, valid=0 and no_signal=1.
REQ-023 Reset mid-period SHALL discard the partial measurement; after release, the first valid SHALL follow the second rise.

Configuration
REQ-024 With macro FREQ_ENCODE_AVG_EN defined, count and high_cnt SHALL be the truncated mean (sum>>2) of 4 consecutive periods, and valid SHALL pulse only on every 4th completed period.
REQ-025 With FREQ_ENCODE_AVG_EN defined, timeout or reset SHALL clear the accumulators and the period index.
REQ-026 Without FREQ_ENCODE_AVG_EN, every completed period SHALL be reported and no accumulator logic SHALL exist.

Structure
REQ-027 Package freq_pkg SHALL hold the FSM state enum typedef, CNT_W_DEF=20, and SYNC_STAGES=2.
REQ-028 Synchronizer plus edge detection SHALL be sub-module edge_sync (outputs: level, rise, fall), instantiated once.

Verification (bench: CNT_W=8, TIMEOUT=200)
REQ-029 Reset check: hold rst_n low with pwm_in toggling -> count=0, high_cnt=0, valid=0, no_signal=1.
REQ-030 Basic measurement: period 100, high 25 -> no valid after the first rise; 4 cycles after the second rise, valid=1 for one cycle with count=100, high_cnt=25, no_signal=0.
REQ-031 Timeout and recovery: after a valid, hold pwm_in low -> 200 cycles after the last rise, no_signal=1, count=0, and no valid; restart pwm_in -> first valid after the second rise.
REQ-032 Timeout tie: period exactly 200 -> valid with count=200, no_signal stays 0.
REQ-033 Reset mid-period: rst_n pulsed low 50 cycles into a period -> outputs go to zero asynchronously; next valid follows two rises after release.
REQ-034 Averaging (FREQ_ENCODE_AVG_EN): periods 100, 102, 98, 101 -> a single valid with count=100 (401>>2).
